fifo_pop_ctrl: RTL

Read-side controller for the push/pop FIFO. It watches the FIFO status flags, issues `pop` while data is available and downstream buffer space exists, and absorbs the FIFO's fixed read latency. It presents each popped word to the next stage on a valid/ready interface. It sits between a FIFO's output and any consumer, such as a demux or arbiter, that can stall.

---
 rtl/fifo_pop_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fifo_pop_ctrl.sv
// Read-side controller for a push/pop FIFO: issues pops under a credit limit,
// absorbs the fixed read latency in a skid buffer, and drives a valid/ready output.
module fifo_pop_ctrl #(
    parameter int data_width = 10,
    parameter int rd_latency = 2,
    parameter int skid_depth = 4,
    parameter int flag_lag   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty_fifo,
    input  logic                  almost_empty_fifo,
    input  logic [data_width-1:0] FIFO_data_out,
    output logic                  pop,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  drained
);

    localparam int ptr_w  = (skid_depth > 1) ? $clog2(skid_depth) : 1;
    localparam int cnt_w  = $clog2(skid_depth + 1);
    localparam int out_w  = $clog2(skid_depth + rd_latency + 1);
    localparam int wait_w = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [rd_latency-1:0] inflight_q, inflight_d;
    logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]      count_q, count_d;
    logic [wait_w-1:0]     wait_q, wait_d;
    logic                  drained_q, drained_d;
    logic [data_width-1:0] mem_q [skid_depth];
    logic [data_width-1:0] mem_d [skid_depth];

    logic [out_w-1:0]      inflight_ones_s;
    logic [out_w-1:0]      outstanding_s;
    logic                  credit_s;
    logic                  ok_s;
    logic                  pop_s;
    logic                  capture_s;
    logic                  xfer_s;

    // Credit: every word already requested must have a guaranteed skid slot.
    always_comb begin
        inflight_ones_s = '0;
        for (int i = 0; i < rd_latency; i++) begin
            inflight_ones_s = inflight_ones_s + out_w'(inflight_q[i]);
        end
        outstanding_s = inflight_ones_s + out_w'(count_q);
        credit_s      = (outstanding_s < out_w'(skid_depth));
        ok_s          = enable & ~empty_fifo & credit_s;
    end

    // Pop FSM: the WAIT dwell lets lagging FIFO flags catch up with the last pops.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ok_s) begin
                    pop_s = 1'b1;
                    if (almost_empty_fifo) begin
                        state_d = ST_WAIT;
                        wait_d  = wait_w'(flag_lag);
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (ok_s) begin
                    pop_s = 1'b1;
                    if (almost_empty_fifo) begin
                        state_d = ST_WAIT;
                        wait_d  = wait_w'(flag_lag);
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_WAIT;
                    wait_d  = wait_w'(flag_lag);
                end
            end
            ST_WAIT: begin
                if (wait_q <= wait_w'(1)) begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end else begin
                    wait_d  = wait_q - wait_w'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    // In-flight pipeline and skid buffer bookkeeping.
    always_comb begin
        inflight_d = rd_latency'({inflight_q, pop_s});
        capture_s  = inflight_q[rd_latency-1];
        xfer_s     = (count_q != '0) & out_ready;
        mem_d      = mem_q;
        if (capture_s) begin
            mem_d[wr_ptr_q] = FIFO_data_out;
            wr_ptr_d        = wr_ptr_q + ptr_w'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (xfer_s) begin
            rd_ptr_d = rd_ptr_q + ptr_w'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({capture_s, xfer_s})
            2'b10:   count_d = count_q + cnt_w'(1);
            2'b01:   count_d = count_q - cnt_w'(1);
            default: count_d = count_q;
        endcase
        drained_d = (state_d == ST_IDLE) && (inflight_d == '0) && (count_d == '0);
    end

    // State registers; reset discards any partially read words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_q     <= '0;
            drained_q  <= 1'b1;
            for (int i = 0; i < skid_depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            drained_q  <= drained_d;
            mem_q      <= mem_d;
        end
    end

    // Pop is gated by reset so it clears the moment reset asserts.
    assign pop       = pop_s & reset;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign drained   = drained_q;

endmodule
